// File: rtl/trigger_router_n_pkg.sv
// Shared trigger-word bit positions and hold-off FSM state type.
package trigger_pkg;

    localparam int unsigned SYN = 0;
    localparam int unsigned TRG = 1;
    localparam int unsigned RSR = 2;
    localparam int unsigned RST = 3;
    localparam int unsigned CAL = 4;

    localparam int unsigned TRIG_NBIT = 5;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } hold_state_t;

endpackage

// File: rtl/trigger_router_n_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + ONE;
        end
    end

endmodule

// File: rtl/trigger_router_n.sv
// Merges gated trigger sources, applies TRG hold-off, routes to TBM and sync
// outputs, and keeps saturating accepted/dropped TRG statistics.
module trigger_router_n
    import trigger_pkg::*;
#(
    parameter int unsigned NSRC   = 5,
    parameter int unsigned NBIT   = TRIG_NBIT,
    parameter int unsigned HOLD_W = 8,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sync,
    input  logic [NSRC-1:0]      sel,
    input  logic [NSRC*NBIT-1:0] src,
    input  logic                 sel_chain,
    input  logic                 sel_sync_out,
    input  logic                 src_sync_direct,
    input  logic [HOLD_W-1:0]    holdoff,
    input  logic                 cnt_clear,
    output logic [NBIT-1:0]      dst_tbm,
    output logic [NBIT-1:0]      dst_sync,
    output logic                 dst_sync_direct,
    output logic                 busy,
    output logic [CNT_W-1:0]     trg_count,
    output logic [CNT_W-1:0]     drop_count
);

    localparam logic [HOLD_W-1:0] HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

    hold_state_t       state;
    hold_state_t       state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_next;
    logic [NBIT-1:0]   sum;
    logic [NBIT-1:0]   filtered;
    logic              accept;
    logic              drop;

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            sum = sum | ({NBIT{sel[i]}} & src[i*NBIT +: NBIT]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
        end
    end

    // RST in the trigger word pulls HOLD back to IDLE behaviour in the same
    // sync cycle, so a coincident TRG is accepted and re-arms the hold-off.
    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        accept        = 1'b0;
        drop          = 1'b0;
        if (sync) begin
            if ((state == HOLD) && !sum[RST]) begin
                drop = sum[TRG];
                if (hold_cnt == HOLD_ONE) begin
                    state_next    = IDLE;
                    hold_cnt_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt - HOLD_ONE;
                end
            end else begin
                accept        = sum[TRG];
                state_next    = IDLE;
                hold_cnt_next = '0;
                if (sum[TRG] && (holdoff != '0)) begin
                    state_next    = HOLD;
                    hold_cnt_next = holdoff;
                end
            end
        end
    end

    always_comb begin
        filtered      = sum;
        filtered[TRG] = accept;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dst_tbm  <= '0;
            dst_sync <= '0;
        end else begin
            dst_tbm  <= sync ? filtered : '0;
            dst_sync <= (sync && sel_sync_out && !sel_chain) ? filtered : '0;
        end
    end

    assign busy            = (state == HOLD);
    assign dst_sync_direct = sel_chain & src_sync_direct;

    sat_counter #(.W(CNT_W)) u_trg_count (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clear),
        .inc   (accept),
        .q     (trg_count)
    );

    sat_counter #(.W(CNT_W)) u_drop_count (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clear),
        .inc   (drop),
        .q     (drop_count)
    );

endmodule

// File: tb/tb_trigger_router_n.sv
// Self-checking bench for trigger_router_n: directed vector table, hand
// sequences, and randomized stimulus against a remaining-dead-time model.
module tb_trigger_router_n;

    logic        clk = 1'b0;
    logic        reset;
    logic        sync;
    logic [4:0]  sel;
    logic [24:0] src;
    logic        sel_chain;
    logic        sel_sync_out;
    logic        src_sync_direct;
    logic [7:0]  holdoff;
    logic        cnt_clear;

    logic [4:0]  dst_tbm, dst_sync, dst_tbm_s, dst_sync_s;
    logic        dst_sync_direct, dst_sync_direct_s, busy, busy_s;
    logic [31:0] trg_count, drop_count;
    logic [3:0]  trg_count_s, drop_count_s;

    always #5 clk = ~clk;

    trigger_router_n dut (
        .clk(clk), .reset(reset), .sync(sync), .sel(sel), .src(src),
        .sel_chain(sel_chain), .sel_sync_out(sel_sync_out),
        .src_sync_direct(src_sync_direct), .holdoff(holdoff), .cnt_clear(cnt_clear),
        .dst_tbm(dst_tbm), .dst_sync(dst_sync), .dst_sync_direct(dst_sync_direct),
        .busy(busy), .trg_count(trg_count), .drop_count(drop_count)
    );

    trigger_router_n #(.CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .sync(sync), .sel(sel), .src(src),
        .sel_chain(sel_chain), .sel_sync_out(sel_sync_out),
        .src_sync_direct(src_sync_direct), .holdoff(holdoff), .cnt_clear(cnt_clear),
        .dst_tbm(dst_tbm_s), .dst_sync(dst_sync_s), .dst_sync_direct(dst_sync_direct_s),
        .busy(busy_s), .trg_count(trg_count_s), .drop_count(drop_count_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: remaining suppressed sync cycles plus plain event tallies.
    int         hold_rem;
    longint     n_acc, n_drop;
    logic [4:0] m_tbm, m_sync;

    function automatic longint sat15(input longint v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic model_edge();
        logic [4:0] word;
        bit acc, drp;
        acc = 0;
        drp = 0;
        if (reset) begin
            hold_rem = 0; n_acc = 0; n_drop = 0; m_tbm = '0; m_sync = '0;
            return;
        end
        word = '0;
        for (int i = 0; i < 5; i++)
            if (sel[i]) word = word | src[i*5 +: 5];
        if (sync) begin
            if (word[3]) hold_rem = 0;
            if (word[1]) begin
                if (hold_rem == 0) begin
                    acc = 1;
                    hold_rem = int'(holdoff);
                end else begin
                    drp = 1;
                    hold_rem--;
                end
            end else if (hold_rem > 0) begin
                hold_rem--;
            end
            word[1] = acc;
            m_tbm  = word;
            m_sync = (sel_sync_out && !sel_chain) ? word : 5'd0;
        end else begin
            m_tbm  = '0;
            m_sync = '0;
        end
        if (cnt_clear) begin
            n_acc = 0;
            n_drop = 0;
        end else begin
            n_acc  += longint'(acc);
            n_drop += longint'(drp);
        end
    endtask

    task automatic tick();
        #1;
        check("direct", {31'd0, dst_sync_direct}, {31'd0, sel_chain & src_sync_direct});
        check("direct_s", {31'd0, dst_sync_direct_s}, {31'd0, sel_chain & src_sync_direct});
        model_edge();
        @(posedge clk);
        #1;
        check("tbm", {27'd0, dst_tbm}, {27'd0, m_tbm});
        check("sync_out", {27'd0, dst_sync}, {27'd0, m_sync});
        check("busy", {31'd0, busy}, {31'd0, hold_rem > 0});
        check("trg_count", trg_count, 32'(n_acc));
        check("drop_count", drop_count, 32'(n_drop));
        check("tbm_s", {27'd0, dst_tbm_s}, {27'd0, m_tbm});
        check("busy_s", {31'd0, busy_s}, {31'd0, hold_rem > 0});
        check("trg_count_s", {28'd0, trg_count_s}, 32'(sat15(n_acc)));
        check("drop_count_s", {28'd0, drop_count_s}, 32'(sat15(n_drop)));
    endtask

    typedef struct {
        bit          s;
        logic [4:0]  sl;
        logic [24:0] sr;
        logic [7:0]  ho;
        bit          clr;
        logic [4:0]  e_tbm;
        bit          e_busy;
        int          e_trg;
        int          e_drop;
    } vec_t;

    vec_t vt[15];

    initial begin
        // Merge/latency, hold-off of 3, then holdoff changed to 0 mid-hold.
        vt[0]  = '{0, 5'b00000, 25'h0,      8'd0, 1, 5'b00000, 0, 0, 0};
        vt[1]  = '{1, 5'b00101, 25'h0004002, 8'd0, 0, 5'b10010, 0, 1, 0};
        vt[2]  = '{0, 5'b00101, 25'h0004002, 8'd0, 0, 5'b00000, 0, 1, 0};
        vt[3]  = '{1, 5'b00001, 25'h2,      8'd3, 0, 5'b00010, 1, 2, 0};
        vt[4]  = '{0, 5'b00001, 25'h2,      8'd3, 0, 5'b00000, 1, 2, 0};
        vt[5]  = '{1, 5'b00001, 25'h2,      8'd3, 0, 5'b00000, 1, 2, 1};
        vt[6]  = '{1, 5'b00001, 25'h2,      8'd3, 0, 5'b00000, 1, 2, 2};
        vt[7]  = '{1, 5'b00001, 25'h2,      8'd3, 0, 5'b00000, 0, 2, 3};
        vt[8]  = '{0, 5'b00001, 25'h2,      8'd3, 0, 5'b00000, 0, 2, 3};
        vt[9]  = '{1, 5'b00001, 25'h2,      8'd3, 0, 5'b00010, 1, 3, 3};
        vt[10] = '{1, 5'b00001, 25'h2,      8'd3, 0, 5'b00000, 1, 3, 4};
        vt[11] = '{1, 5'b00001, 25'h2,      8'd0, 0, 5'b00000, 1, 3, 5};
        vt[12] = '{1, 5'b00001, 25'h2,      8'd0, 0, 5'b00000, 0, 3, 6};
        vt[13] = '{1, 5'b00001, 25'h2,      8'd0, 0, 5'b00010, 0, 4, 6};
        vt[14] = '{1, 5'b00001, 25'h2,      8'd0, 0, 5'b00010, 0, 5, 6};

        reset = 1; sync = 0; sel = '0; src = '0; sel_chain = 0; sel_sync_out = 1;
        src_sync_direct = 0; holdoff = '0; cnt_clear = 0;
        hold_rem = 0; n_acc = 0; n_drop = 0; m_tbm = '0; m_sync = '0;
        @(posedge clk);
        #1;
        tick();
        check("reset_tbm", {27'd0, dst_tbm}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_trg", trg_count, 32'd0);
        reset = 0;

        // Idle with nothing selected.
        for (int i = 0; i < 20; i++) begin
            sync = (i % 2 == 0);
            src = 25'($urandom);
            holdoff = 8'd2;
            tick();
            check("idle_tbm", {27'd0, dst_tbm}, 32'd0);
            check("idle_cnt", trg_count | drop_count, 32'd0);
        end

        for (int r = 0; r < 15; r++) begin
            sync = vt[r].s; sel = vt[r].sl; src = vt[r].sr;
            holdoff = vt[r].ho; cnt_clear = vt[r].clr;
            tick();
            check($sformatf("vec%0d_tbm", r), {27'd0, dst_tbm}, {27'd0, vt[r].e_tbm});
            check($sformatf("vec%0d_sync", r), {27'd0, dst_sync}, {27'd0, vt[r].e_tbm});
            check($sformatf("vec%0d_busy", r), {31'd0, busy}, {31'd0, vt[r].e_busy});
            check($sformatf("vec%0d_trg", r), trg_count, 32'(vt[r].e_trg));
            check($sformatf("vec%0d_drop", r), drop_count, 32'(vt[r].e_drop));
        end

        // RST during HOLD re-arms the full hold-off.
        sync = 0; src = '0; sel = 5'b00011; cnt_clear = 1; holdoff = 8'd10;
        tick();
        cnt_clear = 0; sync = 1; src = 25'h2;
        tick();
        src = 25'h0;
        tick();
        src = 25'h000A << 5;
        tick();
        check("rst_hold_tbm", {27'd0, dst_tbm}, 32'h0A);
        check("rst_hold_busy", {31'd0, busy}, 32'd1);
        check("rst_hold_trg", trg_count, 32'd2);
        check("rst_hold_drop", drop_count, 32'd0);
        src = '0;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("rst_hold_window", {31'd0, busy}, 32'd1);
        end
        tick();
        check("rst_hold_end", {31'd0, busy}, 32'd0);

        // Chain routing.
        holdoff = '0; sel = 5'b00001; src = 25'h2; sel_chain = 1; src_sync_direct = 1;
        #1;
        check("chain_direct_hi", {31'd0, dst_sync_direct}, 32'd1);
        tick();
        check("chain_sync_blocked", {27'd0, dst_sync}, 32'd0);
        check("chain_tbm", {27'd0, dst_tbm}, 32'h02);
        src_sync_direct = 0;
        #1;
        check("chain_direct_lo", {31'd0, dst_sync_direct}, 32'd0);
        sel_chain = 0; src_sync_direct = 1;
        tick();
        check("nochain_sync", {27'd0, dst_sync}, {27'd0, dst_tbm});
        check("nochain_direct", {31'd0, dst_sync_direct}, 32'd0);

        // Saturation at 4 bits, then clear with a coincident TRG.
        cnt_clear = 1; sync = 0;
        tick();
        cnt_clear = 0; sync = 1;
        for (int i = 0; i < 20; i++) tick();
        check("sat_small", {28'd0, trg_count_s}, 32'd15);
        check("sat_big", trg_count, 32'd20);
        cnt_clear = 1;
        tick();
        check("clr_small", {28'd0, trg_count_s}, 32'd0);
        check("clr_big", trg_count, 32'd0);
        cnt_clear = 0;

        // Randomized traffic including rare resets and clears.
        for (int i = 0; i < 600; i++) begin
            logic [24:0] w;
            reset = ($urandom_range(0, 59) == 0);
            cnt_clear = ($urandom_range(0, 39) == 0);
            sync = ($urandom_range(0, 3) != 0);
            sel = 5'($urandom);
            w = 25'($urandom);
            for (int k = 0; k < 5; k++)
                if ($urandom_range(0, 9) != 0) w[k*5 + 3] = 1'b0;
            src = w;
            if ($urandom_range(0, 7) == 0) holdoff = 8'($urandom_range(0, 6));
            sel_chain = ($urandom_range(0, 3) == 0);
            sel_sync_out = ($urandom_range(0, 3) != 0);
            src_sync_direct = 1'($urandom);
            tick();
        end
        reset = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trigger_router_n.md
Name: trigger_router_n

Overview:
- Parametrised, registered successor of the DTB trigger switch.
- Merges NSRC gated trigger sources into one trigger word and routes it to the soft-TBM and data-trigger (sync) outputs.
- Adds a programmable trigger hold-off (dead-time) state machine and saturating accepted/dropped trigger counters for rate monitoring.
- Sits between the trigger sources (async, sync, single, generator, pattern generator, spare) and the TBM/sync-out logic.

Parameters:
- NSRC, 5, number of trigger sources.
- NBIT, 5, trigger word width; bit order is syn, trg, rsr, rst, cal (from shared package).
- HOLD_W, 8, width of the hold-off length.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sync  in  1  trigger-clock enable; state advances only when sync=1.
- sel  in  NSRC  per-source enable; bit i gates source i.
- src  in  NSRC*NBIT  source words; source i occupies bits [i*NBIT +: NBIT].
- sel_chain  in  1  pass src_sync_direct to dst_sync_direct and block dst_sync.
- sel_sync_out  in  1  enable trigger data on dst_sync.
- src_sync_direct  in  1  fast chain input.
- holdoff  in  HOLD_W  dead time in sync cycles after an accepted TRG; 0 disables hold-off.
- cnt_clear  in  1  synchronous clear of both counters.
- dst_tbm  out  NBIT  merged trigger word to the soft TBM.
- dst_sync  out  NBIT  merged trigger word to the sync output.
- dst_sync_direct  out  1  chained direct output; combinational.
- busy  out  1  hold-off active.
- trg_count  out  CNT_W  accepted TRG count.
- drop_count  out  CNT_W  suppressed TRG count.

Behaviour:
- Reset: all outputs are 0; FSM enters IDLE; hold counter is 0; reset mid-hold aborts the hold immediately.
- Merge: sum = OR over i of ({NBIT{sel[i]}} & src_i). Simultaneous TRG from several sources counts as one trigger.
- Output timing:
  - dst_tbm and dst_sync are registered.
  - On a clk edge with sync=1 they load the filtered sum, giving 1-clk latency.
  - On a clk edge with sync=0 they load 0, so every pulse is exactly one clk wide.
- Filtering: filtered = sum, except the TRG bit is cleared while the FSM is in HOLD. SYN, RSR, RST and CAL are never suppressed.
- dst_sync = filtered when sel_sync_out=1 and sel_chain=0; otherwise 0.
- dst_sync_direct = sel_chain & src_sync_direct. This path is combinational with no latency.
- FSM (advances only on sync=1):
  - IDLE: if sum[TRG]=1 and holdoff≠0, accept the TRG, load hold counter with holdoff, and go to HOLD. If holdoff=0, accept the TRG and stay in IDLE.
  - HOLD: decrement the counter each sync cycle. sum[TRG]=1 is dropped. When the counter reaches 1 on a sync cycle, go to IDLE. Hold-off therefore suppresses exactly holdoff sync cycles after the accept cycle.
  - sum[RST]=1 in any state forces IDLE on the same sync cycle. If TRG is also set in that cycle, it is evaluated as in IDLE (accepted).
  - A holdoff change during HOLD does not affect the running count; it applies from the next accept.
- busy = 1 iff state is HOLD (registered).
- Counters:
  - trg_count increments on each accepted TRG; drop_count increments on each dropped TRG.
  - Both saturate at all-ones with no wrap.
  - cnt_clear has priority over increment and clears regardless of sync.
  - Counters are also cleared by reset.
- A source whose sel bit is 0 has no effect on any output or counter.

Decomposition:
- Package trigger_pkg holds:
  - localparams SYN=0, TRG=1, RSR=2, RST=3, CAL=4;
  - default NBIT=5;
  - FSM state enum {IDLE, HOLD}.
- Sub-module sat_counter (parameter W; ports clk, reset, clr, inc, q) is instantiated twice.

Test Plan:
- Reset then idle: with sync toggling 1/0 and all sel=0, dst_tbm=0, dst_sync=0, busy=0 and both counts=0 for 20 cycles.
- Merge/latency: sel=5'b00101, src0 trg=1, src2 cal=1 on a sync cycle -> next clk dst_tbm=5'b10010; following clk dst_tbm=0; trg_count=1.
- Hold-off: holdoff=3 with TRG on sync cycles 0..5 -> TRG is accepted at 0 and 4 and dropped at 1-3; trg_count=2 at cycle 4; busy is high exactly for the intended hold window.
- RST during HOLD: holdoff=10, TRG at 0, RST+TRG at 2 -> both forwarded at 2; busy restarts (holdoff=10 reloaded); drop_count=0.
- Routing: sel_sync_out=1, sel_chain=1 -> dst_sync=0 and dst_sync_direct follows src_sync_direct same cycle; with sel_chain=0, dst_sync equals dst_tbm.
- Saturation/clear: CNT_W=4 with 20 accepted TRG -> trg_count=15; cnt_clear pulse with simultaneous TRG -> trg_count=0.
